onehot_encoder_hs: RTL and testbench
====================================

Name: onehot_encoder_hs

Overview:
- Registered one-hot-to-binary encoder with valid/ready handshakes on both sides.
- It is the inverse of the team's 2x4 decoder, which drives code k as bit (N-1-k) of the one-hot vector: code 0 -> 4'b1000, code 3 -> 4'b0001.
- Sits downstream of decoder-driven select/grant lines and re-packs them into a compact code.
- Flags malformed input (all-zero or multi-hot) and keeps a saturating error count.

Parameters:
- N, 4, one-hot input width; legal values 2, 4, 8.
- CW, 2, output code width; must equal log2(N).
- ECW, 8, error counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_onehot is valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- in_onehot  input  N  one-hot vector; bit (N-1-k) encodes code k.
- out_valid  output  1  out_code and its flags are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_code  output  CW  encoded value.
- out_zero  output  1  the accepted vector was all zero.
- out_multi  output  1  the accepted vector had more than one bit set.
- err_count  output  ECW  saturating count of accepted zero or multi-hot vectors.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_code=0, out_zero=0, out_multi=0, err_count=0.
  - State goes to EMPTY.
  - in_ready=0 while rst_n is low.
  - An in-flight output is discarded, with no completion.
- State machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with simultaneous accept, or on no drain.
- Handshake rules:
  - in_ready = rst_n & (state==EMPTY | out_ready). This is combinational and must not depend on in_valid.
  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
  - Latency: a vector accepted in cycle t appears on out_code/out_valid in cycle t+1.
  - Sustained throughput is 1 vector per cycle when out_ready is held high.
  - While out_valid=1 and out_ready=0, out_code, out_zero and out_multi hold stable.
  - Accept and drain in the same cycle: the new result replaces the old one with no bubble.
- Encoding:
  - Exactly one bit set at position p: out_code = N-1-p, out_zero=0, out_multi=0.
  - Multi-hot: priority goes to the highest set index p, which gives the lowest code. out_code = N-1-p and out_multi=1.
  - All zero: out_code=0, out_zero=1, out_multi=0.
- err_count:
  - Increments by 1 on each accept with a zero or multi-hot vector.
  - Saturates at 2^ECW-1; it never wraps.
  - It is not affected by out_ready.
- in_onehot is sampled only on accept. Changes while in_ready=0 are ignored.
- Round-trip property: for every code k, decoding k with the team decoder and then encoding the result returns k with both flags 0.

Test Plan:
- Reset with out_ready=1, then in_valid=1 with in_onehot=1000, 0100, 0010, 0001 on consecutive cycles -> out_code=0,1,2,3 on cycles t+1..t+4; out_valid stays 1 throughout; flags 0; err_count=0.
- in_onehot=0110 -> out_code=1, out_multi=1, err_count=1; then 0000 -> out_code=0, out_zero=1, err_count=2.
- Backpressure: hold out_ready=0 after one accept of 0010 -> in_ready=0, and out_code=2 stays stable for 5 cycles while in_onehot toggles. Raise out_ready together with in_onehot=1000 -> output 2 drains and 0 appears on the next cycle with no bubble.
- Apply 260 consecutive 1111 inputs -> err_count saturates at 255, out_code=0 each time.
- Assert rst_n=0 mid-stream while out_valid=1 with out_code=3 -> out_valid, out_code and err_count go to 0 immediately, with no clock edge needed; in_ready=0 until release.
- Round trip: drive codes 0..3 through the team 2x4 decoder into the block -> out_code equals the driven code for all four, with flags 0.

Source files
------------

// File: rtl/onehot_encoder_hs_if.sv
// onehot_encoder_hs_if: handshake bundle between a one-hot producer, the encoder and the code consumer
interface onehot_encoder_hs_if #(
    parameter int N   = 4,
    parameter int CW  = $clog2(N),
    parameter int ECW = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_onehot;
    logic           out_valid;
    logic           out_ready;
    logic [CW-1:0]  out_code;
    logic           out_zero;
    logic           out_multi;
    logic [ECW-1:0] err_count;

    modport master (
        output in_valid, in_onehot, out_ready,
        input  in_ready, out_valid, out_code, out_zero, out_multi, err_count
    );

    modport slave (
        input  in_valid, in_onehot, out_ready,
        output in_ready, out_valid, out_code, out_zero, out_multi, err_count
    );
endinterface

// File: rtl/onehot_encoder_hs.sv
// onehot_encoder_hs: registered one-hot to binary encoder with valid/ready on both sides and malformed-input flags
module onehot_encoder_hs #(
    parameter int N   = 4,
    parameter int CW  = 2,
    parameter int ECW = 8
) (
    input logic               clk,
    input logic               rst_n,
    onehot_encoder_hs_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state_q;
    logic [CW-1:0]  code_q, code_d;
    logic           zero_q, zero_d;
    logic           multi_q, multi_d;
    logic [ECW-1:0] err_q, err_d;
    logic           accept;

    // Decoder drives code k on bit N-1-k, so the highest set bit wins and yields the lowest code
    always_comb begin
        code_d = '0;
        for (int p = 0; p < N; p++) code_d = bus.in_onehot[p] ? CW'(N - 1 - p) : code_d;
        zero_d  = ~|bus.in_onehot;
        multi_d = |(bus.in_onehot & (bus.in_onehot - N'(1)));
        err_d   = ((zero_d | multi_d) && err_q != '1) ? err_q + ECW'(1) : err_q;
    end

    // The slot can take a new vector when empty or when the held one leaves this cycle
    assign bus.in_ready  = rst_n & (state_q == EMPTY | bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = state_q == FULL;
    assign bus.out_code  = code_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_multi = multi_q;
    assign bus.err_count = err_q;

    // Output slot: an accept always (re)fills it, a drain without accept empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            code_q  <= '0;
            zero_q  <= 1'b0;
            multi_q <= 1'b0;
            err_q   <= '0;
        end else if (accept) begin
            state_q <= FULL;
            code_q  <= code_d;
            zero_q  <= zero_d;
            multi_q <= multi_d;
            err_q   <= err_d;
        end else if (bus.out_ready) begin
            state_q <= EMPTY;
        end
    end
endmodule

// File: tb/tb_onehot_encoder_hs.sv
// tb_onehot_encoder_hs: directed-vector bench for the handshaked one-hot encoder
module tb_onehot_encoder_hs;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    onehot_encoder_hs_if #(.N(4), .CW(2), .ECW(8)) bus ();

    onehot_encoder_hs #(.N(4), .CW(2), .ECW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Team 2x4 decoder: code k drives bit 3-k
    function automatic logic [3:0] dec(input int k);
        logic [3:0] top;
        top = 4'b1000;
        return top >> k;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_onehot = 4'b0000;
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_code !== 2'd0) begin miscompares++; $display("FAIL reset_code got %0d want 0", bus.out_code); end
        vectors++; if (bus.out_zero !== 1'b0 || bus.out_multi !== 1'b0) begin miscompares++; $display("FAIL reset_flags got %b%b want 00", bus.out_zero, bus.out_multi); end
        vectors++; if (bus.err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err got %0d want 0", bus.err_count); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        step();
        step();
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_sequence();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_onehot = dec(k);
            step();
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL seq_valid k=%0d got %b want 1", k, bus.out_valid); end
            vectors++; if (bus.out_code !== 2'(k)) begin miscompares++; $display("FAIL seq_code got %0d want %0d", bus.out_code, k); end
            vectors++; if (bus.out_zero !== 1'b0 || bus.out_multi !== 1'b0) begin miscompares++; $display("FAIL seq_flags k=%0d got %b%b want 00", k, bus.out_zero, bus.out_multi); end
            vectors++; if (bus.err_count !== 8'd0) begin miscompares++; $display("FAIL seq_err k=%0d got %0d want 0", k, bus.err_count); end
        end
    endtask

    task automatic test_errors();
        bus.in_onehot = 4'b0110;
        step();
        vectors++; if (bus.out_code !== 2'd1) begin miscompares++; $display("FAIL multi_code got %0d want 1", bus.out_code); end
        vectors++; if (bus.out_multi !== 1'b1 || bus.out_zero !== 1'b0) begin miscompares++; $display("FAIL multi_flags got z%b m%b want z0 m1", bus.out_zero, bus.out_multi); end
        vectors++; if (bus.err_count !== 8'd1) begin miscompares++; $display("FAIL multi_err got %0d want 1", bus.err_count); end
        bus.in_onehot = 4'b0000;
        step();
        vectors++; if (bus.out_code !== 2'd0) begin miscompares++; $display("FAIL zero_code got %0d want 0", bus.out_code); end
        vectors++; if (bus.out_zero !== 1'b1 || bus.out_multi !== 1'b0) begin miscompares++; $display("FAIL zero_flags got z%b m%b want z1 m0", bus.out_zero, bus.out_multi); end
        vectors++; if (bus.err_count !== 8'd2) begin miscompares++; $display("FAIL zero_err got %0d want 2", bus.err_count); end
    endtask

    task automatic test_backpressure();
        bus.in_onehot = 4'b0010;
        step();
        vectors++; if (bus.out_code !== 2'd2) begin miscompares++; $display("FAIL bp_first got %0d want 2", bus.out_code); end
        bus.out_ready = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
        for (int i = 0; i < 5; i++) begin
            bus.in_onehot = i[0] ? 4'b1111 : 4'b0001;
            step();
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_code !== 2'd2) begin miscompares++; $display("FAIL bp_hold i=%0d got v%b c%0d want v1 c2", i, bus.out_valid, bus.out_code); end
            vectors++; if (bus.out_zero !== 1'b0 || bus.out_multi !== 1'b0 || bus.err_count !== 8'd2) begin miscompares++; $display("FAIL bp_flags i=%0d got z%b m%b e%0d want z0 m0 e2", i, bus.out_zero, bus.out_multi, bus.err_count); end
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall_ready i=%0d got %b want 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        bus.in_onehot = 4'b1000;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
        step();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_code !== 2'd0) begin miscompares++; $display("FAIL bp_no_bubble got v%b c%0d want v1 c0", bus.out_valid, bus.out_code); end
        bus.in_valid = 1'b0;
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got %b want 0", bus.out_valid); end
        bus.out_ready = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL empty_ready got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_saturation();
        int exp_err;
        exp_err = 2;
        bus.in_valid = 1'b1;
        bus.in_onehot = 4'b1111;
        for (int i = 0; i < 260; i++) begin
            step();
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            vectors++; if (bus.err_count !== 8'(exp_err) || bus.out_code !== 2'd0 || bus.out_multi !== 1'b1) begin miscompares++; $display("FAIL sat i=%0d got e%0d c%0d m%b want e%0d c0 m1", i, bus.err_count, bus.out_code, bus.out_multi, exp_err); end
        end
        vectors++; if (bus.err_count !== 8'd255) begin miscompares++; $display("FAIL sat_final got %0d want 255", bus.err_count); end
    endtask

    task automatic test_async_reset();
        bus.in_onehot = 4'b0001;
        step();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_code !== 2'd3) begin miscompares++; $display("FAIL pre_reset got v%b c%0d want v1 c3", bus.out_valid, bus.out_code); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_code !== 2'd0) begin miscompares++; $display("FAIL async_out got v%b c%0d want v0 c0", bus.out_valid, bus.out_code); end
        vectors++; if (bus.err_count !== 8'd0) begin miscompares++; $display("FAIL async_err got %0d want 0", bus.err_count); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL async_ready got %b want 0", bus.in_ready); end
        step();
        vectors++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL held_reset got r%b v%b want r0 v0", bus.in_ready, bus.out_valid); end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL async_release got %b want 1", bus.in_ready); end
    endtask

    task automatic test_round_trip();
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            bus.in_onehot = dec(k);
            step();
            vectors++; if (bus.out_code !== 2'(k) || bus.out_zero !== 1'b0 || bus.out_multi !== 1'b0) begin miscompares++; $display("FAIL round_trip got c%0d z%b m%b want c%0d z0 m0", bus.out_code, bus.out_zero, bus.out_multi, k); end
        end
        vectors++; if (bus.err_count !== 8'd0) begin miscompares++; $display("FAIL round_trip_err got %0d want 0", bus.err_count); end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_sequence();
        test_errors();
        test_backpressure();
        test_saturation();
        test_async_reset();
        test_round_trip();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
